// File: rtl/ccff_chain_loader.sv
// ccff_chain_loader: serialises bitstream words onto the config chain, with optional CRC-8 recirculate verify.
module ccff_chain_loader #(
    parameter int WORD_W    = 8,
    parameter int CHAIN_LEN = 26,
    parameter int CNT_W     = 16
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              start,
    input  logic              verify_en,
    input  logic [WORD_W-1:0] word_data,
    input  logic              word_valid,
    output logic              word_ready,
    output logic              ccff_head,
    input  logic              ccff_tail,
    output logic              prog_clk_en,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [CNT_W-1:0]  bit_count
);
    localparam int WB_W = $clog2(WORD_W + 1);
    typedef enum logic [2:0] {IDLE, FETCH, SHIFT, VERIFY, DONE} state_t;
    state_t state_q, state_d;
    logic [WORD_W-1:0] sreg_q, sreg_d;
    logic [WB_W-1:0]   wbit_q, wbit_d;
    logic [CNT_W-1:0]  bit_count_q, bit_count_d, bit_inc;
    logic [7:0]        crc_tx_q, crc_tx_d, crc_rx_q, crc_rx_d;
    logic              vfy_q, vfy_d, error_q, error_d;
    function automatic logic [7:0] crc8(input logic [7:0] c, input logic b);
        return {c[6:0], 1'b0} ^ ((c[7] ^ b) ? 8'h07 : 8'h00);
    endfunction
    assign bit_inc = (bit_count_q == CNT_W'(CHAIN_LEN)) ? bit_count_q : bit_count_q + 1'b1;
    always_comb begin
        state_d     = state_q;
        sreg_d      = sreg_q;
        wbit_d      = wbit_q;
        bit_count_d = bit_count_q;
        crc_tx_d    = crc_tx_q;
        crc_rx_d    = crc_rx_q;
        vfy_d       = vfy_q;
        error_d     = error_q;
        case (state_q)
            IDLE: if (start) begin
                state_d     = FETCH;
                bit_count_d = '0;
                crc_tx_d    = '0;
                crc_rx_d    = '0;
                vfy_d       = verify_en;
                error_d     = 1'b0;
            end
            FETCH: if (word_valid) begin
                sreg_d  = word_data;
                wbit_d  = '0;
                state_d = SHIFT;
            end
            SHIFT: begin
                sreg_d      = sreg_q >> 1;
                wbit_d      = wbit_q + 1'b1;
                bit_count_d = bit_inc;
                crc_tx_d    = crc8(crc_tx_q, sreg_q[0]);
                // the last word is partial: leaving on the chain length drops its upper bits
                if (bit_inc == CNT_W'(CHAIN_LEN)) begin
                    state_d     = vfy_q ? VERIFY : DONE;
                    bit_count_d = vfy_q ? '0 : bit_inc;
                end else if (wbit_q == WB_W'(WORD_W - 1)) begin
                    state_d = FETCH;
                end
            end
            VERIFY: begin
                bit_count_d = bit_inc;
                crc_rx_d    = crc8(crc_rx_q, ccff_tail);
                if (bit_inc == CNT_W'(CHAIN_LEN)) begin
                    error_d = crc8(crc_rx_q, ccff_tail) != crc_tx_q;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            state_q     <= IDLE;
            sreg_q      <= '0;
            wbit_q      <= '0;
            bit_count_q <= '0;
            crc_tx_q    <= '0;
            crc_rx_q    <= '0;
            vfy_q       <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            sreg_q      <= sreg_d;
            wbit_q      <= wbit_d;
            bit_count_q <= bit_count_d;
            crc_tx_q    <= crc_tx_d;
            crc_rx_q    <= crc_rx_d;
            vfy_q       <= vfy_d;
            error_q     <= error_d;
        end
    end
    assign prog_clk_en = (state_q == SHIFT) || (state_q == VERIFY);
    assign ccff_head   = (state_q == SHIFT) ? sreg_q[0] : (state_q == VERIFY) ? ccff_tail : 1'b0;
    assign word_ready  = state_q == FETCH;
    assign busy        = state_q != IDLE;
    assign done        = state_q == DONE;
    assign error       = error_q;
    assign bit_count   = bit_count_q;
endmodule

// File: tb/tb_ccff_chain_loader.sv
// tb_ccff_chain_loader: directed checks of load, verify, stall, reset abort and ignored requests.
module tb_ccff_chain_loader;
    logic        prog_clk = 1'b0, pReset, start, verify_en, word_valid, ccff_tail;
    logic [7:0]  word_data;
    logic        word_ready, ccff_head, prog_clk_en, busy, done, error;
    logic [15:0] bit_count;
    logic [25:0] chain, hs;
    logic [7:0]  words [4] = '{8'hA5, 8'h3C, 8'hFF, 8'h02};
    localparam logic [25:0] EXP = {2'b10, 8'hFF, 8'h3C, 8'hA5};
    int checks = 0, failures = 0;
    int idx, gap_left, flip_cyc, start_cyc, cyc, en_cnt, done_cnt, done_cyc, ready_bad;
    logic flip, acc, err_at1;

    ccff_chain_loader dut (
        .prog_clk(prog_clk), .pReset(pReset), .start(start), .verify_en(verify_en),
        .word_data(word_data), .word_valid(word_valid), .word_ready(word_ready),
        .ccff_head(ccff_head), .ccff_tail(ccff_tail), .prog_clk_en(prog_clk_en),
        .busy(busy), .done(done), .error(error), .bit_count(bit_count)
    );

    always #5 prog_clk = ~prog_clk;
    always @(posedge prog_clk) if (prog_clk_en) chain <= {ccff_head, chain[25:1]};
    assign ccff_tail = chain[0] ^ flip;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        cyc++;
        start      = (cyc == start_cyc);
        flip       = (cyc == flip_cyc);
        word_data  = words[idx < 4 ? idx : 3];
        word_valid = (idx < 4) && !(gap_left > 0 && idx == 2);
        if (gap_left > 0 && idx == 2 && word_ready) gap_left--;
        acc = word_valid && word_ready;
        if (word_ready && (prog_clk_en || !busy || done)) ready_bad++;
        if (prog_clk_en) begin
            if (en_cnt < 26) hs[en_cnt] = ccff_head;
            en_cnt++;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        @(posedge prog_clk);
        #1;
        if (acc) idx++;
        start = 1'b0;
        flip  = 1'b0;
    endtask

    task automatic begin_load(input logic v, input int gap, input int flip_c, input int start_c);
        idx = 0; gap_left = gap; flip_cyc = flip_c; start_cyc = start_c;
        cyc = 0; en_cnt = 0; done_cnt = 0; done_cyc = 0; ready_bad = 0; hs = '0;
        start = 1'b1; verify_en = v;
        @(posedge prog_clk);
        #1;
        start = 1'b0; verify_en = 1'b0;
        err_at1 = error;
    endtask

    task automatic load(input logic v, input int gap, input int flip_c, input int start_c);
        begin_load(v, gap, flip_c, start_c);
        while (done_cnt == 0 && cyc < 400) step();
        step();
    endtask

    initial begin
        pReset = 1'b1; start = 1'b0; verify_en = 1'b0; word_valid = 1'b0; word_data = '0; flip = 1'b0;
        repeat (2) @(posedge prog_clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_outs", {done, error, word_ready, prog_clk_en, ccff_head}, 0);
        check("rst_bit_count", bit_count, 0);
        pReset = 1'b0;

        load(1'b0, 0, -1, -1);
        check("t1_head_stream", hs, EXP);
        check("t1_chain", chain, EXP);
        check("t1_done_cyc", done_cyc, 31);
        check("t1_done_cnt", done_cnt, 1);
        check("t1_en_cnt", en_cnt, 26);
        check("t1_ready_only_fetch", ready_bad, 0);
        check("t1_bit_count", bit_count, 26);
        check("t1_idle", busy, 0);

        load(1'b1, 0, -1, -1);
        check("t2_chain", chain, EXP);
        check("t2_en_cnt", en_cnt, 52);
        check("t2_done_cyc", done_cyc, 57);
        check("t2_done_cnt", done_cnt, 1);
        check("t2_error", error, 0);

        load(1'b1, 0, 40, -1);
        check("t3_done_cnt", done_cnt, 1);
        check("t3_error", error, 1);
        repeat (3) step();
        check("t3_error_held", error, 1);
        load(1'b0, 0, -1, -1);
        check("t3_error_cleared_on_start", err_at1, 0);
        check("t3_reload_chain", chain, EXP);

        load(1'b0, 5, -1, -1);
        check("t4_chain", chain, EXP);
        check("t4_done_cyc", done_cyc, 36);
        check("t4_en_cnt", en_cnt, 26);
        check("t4_head_stream", hs, EXP);

        begin_load(1'b0, 0, -1, -1);
        while (bit_count !== 16'd10 && cyc < 100) step();
        check("t5_reached_10", {prog_clk_en, bit_count}, {1'b1, 16'd10});
        pReset = 1'b1;
        @(posedge prog_clk);
        #1;
        pReset = 1'b0;
        check("t5_busy", busy, 0);
        check("t5_bit_count", bit_count, 0);
        done_cnt = 0;
        repeat (4) step();
        check("t5_no_done", done_cnt, 0);
        load(1'b0, 0, -1, -1);
        check("t5_reload_chain", chain, EXP);
        check("t5_reload_done_cyc", done_cyc, 31);

        word_valid = 1'b1; word_data = words[0];
        repeat (3) begin
            @(posedge prog_clk);
            #1;
            check("t6_ready_idle", word_ready, 0);
        end
        load(1'b0, 0, -1, 5);
        check("t6_words_consumed", idx, 4);
        check("t6_chain", chain, EXP);
        check("t6_done_cyc", done_cyc, 31);
        check("t6_done_cnt", done_cnt, 1);
        check("t6_ready_only_fetch", ready_bad, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
